// File: rtl/bcd_cascade_counter_pkg.sv
// bcd_cascade_counter_pkg: shared BCD digit type,
// digit limits and load-legality helper.
package bcd_cascade_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_cascade_counter_digit_cell.sv
// bcd_digit_cell: one decade digit with load,
// up/down step and carry/borrow out.
module bcd_digit_cell
  import bcd_cascade_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_digit,
  input  logic       step,
  input  logic       up_dn,
  output logic [3:0] q,
  output logic       at_lim,
  output logic       co
);

  bcd_digit_t nxt;

  // limit test and next digit; an out-of-range
  // digit counts as 9 and steps to 0 or 8
  always_comb begin
    at_lim = up_dn ? (q >= BCD_MAX)
                   : (q == BCD_MIN);
    co     = step && at_lim;
    nxt    = q;
    if (up_dn) begin
      nxt = at_lim ? BCD_MIN : q + 4'd1;
    end else if (q == BCD_MIN) begin
      nxt = BCD_MAX;
    end else if (q > BCD_MAX) begin
      nxt = 4'd8;
    end else begin
      nxt = q - 4'd1;
    end
  end

  // digit register: reset > load > step
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= is_bcd(ld_digit) ? ld_digit : BCD_MIN;
    end else if (step) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bcd_cascade_counter.sv
// bcd_cascade_counter: DIGITS-wide BCD counter,
// wrap or saturate, tc/ovf/load_err outputs.
module bcd_cascade_counter
  import bcd_cascade_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slowena,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                ovf,
  output logic                load_err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] lim;
  logic [DIGITS-1:0] co;
  logic              bad;
  logic              evt;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_first
      // saturating mode freezes the chain at range end
      assign step[i] = slowena && !(!WRAP && tc);
    end else begin : g_rest
      assign step[i] = co[i-1];
    end
    bcd_digit_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .ld_digit (load_val[4*i +: 4]),
      .step     (step[i]),
      .up_dn    (up_dn),
      .q        (q[4*i +: 4]),
      .at_lim   (lim[i]),
      .co       (co[i])
    );
  end

  // terminal count, range-end event, illegal load
  always_comb begin
    tc  = slowena && (&lim);
    evt = WRAP ? co[DIGITS-1] : tc;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_bcd(load_val[4*i +: 4])) bad = 1'b1;
    end
  end

  // one-cycle status pulses aligned with q
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      ovf      <= !load && evt;
      load_err <= load && bad;
    end
  end

endmodule

// File: doc/bcd_cascade_counter.md
Name: bcd_cascade_counter

Overview:
- Parametrised multi-digit BCD (decade) counter, the generalised successor of the single-digit slow decade counter.
- Counts up or down on a qualifying enable, supports parallel load, and can either wrap or saturate at the end of range.
- Provides a terminal-count output for cascading and a registered overflow pulse.
- Sits in display/timebase paths, driven by a slow enable strobe from a prescaler.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1.
- WRAP, 1, 1 = wrap at range end; 0 = saturate (hold at the limit).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- slowena  input  1  count enable; one count step per clk cycle where high.
- up_dn  input  1  1 = count up, 0 = count down; sampled with slowena.
- load  input  1  parallel load strobe.
- load_val  input  4*DIGITS  BCD value to load; digit i is bits [4i+3:4i].
- q  output  4*DIGITS  registered BCD count; digit 0 is least significant.
- tc  output  1  combinational terminal count: slowena && ((up_dn && q == all 9s) || (!up_dn && q == all 0s)).
- ovf  output  1  registered one-cycle pulse, the cycle after a range-end event while slowena is high.
- load_err  output  1  registered one-cycle pulse, the cycle after a load containing any digit > 9.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Priority per edge: reset > load > slowena > hold.
- Reset: q = 0, ovf = 0, load_err = 0; tc follows from q and inputs. Reset mid-count or mid-load discards the operation.
- Load: each digit of q takes the matching load_val digit. Any digit > 9 is loaded as 0 instead. load_err = 1 next cycle if any digit was > 9.
- Load with slowena high: the load wins, no count step that cycle, and ovf = 0.
- Counting up: digit 0 increments; 9 -> 0 with a carry into the next digit; carries ripple combinationally in the same cycle.
- Counting down: digit 0 decrements; 0 -> 9 with a borrow into the next digit; borrows ripple the same way.
- Range end up (q = all 9s, slowena = 1, up_dn = 1):
  - WRAP = 1: q -> all 0s.
  - WRAP = 0: q holds.
  - In both modes ovf = 1 the next cycle.
- Range end down (q = all 0s, slowena = 1, up_dn = 0):
  - WRAP = 1: q -> all 9s.
  - WRAP = 0: q holds at 0.
  - In both modes ovf = 1 the next cycle.
- slowena = 0: q holds, no ovf, tc = 0.
- Latency: q reflects a step or load one cycle after the qualifying edge. ovf and load_err are coincident with the updated q.
- Direction change: up_dn may change any cycle; it takes effect on the same edge it is sampled.
- Invariant: every digit of q is always in the range 0..9. An illegal state is unreachable; if forced, the digit is treated as 9 for the range-end test and steps to 0 (up) or 8 (down).
- Cascading: tc of one instance drives slowena of the next instance; a shared up_dn keeps the instances consistent.

Decomposition:
- Shared package holds:
  - constant BCD_MAX = 4'd9 and BCD_MIN = 4'd0;
  - a bcd_digit_t 4-bit typedef;
  - a function is_bcd(d) used for the load check.
- One natural sub-module, bcd_digit_cell:
  - inputs: clk, reset, load, load digit, step enable (slowena AND carry-in), up_dn;
  - outputs: digit q and carry/borrow-out (digit at 9 going up, or at 0 going down, while stepping).
- The top generates DIGITS cells in a chain and adds the tc, ovf and load_err logic.

Test Plan (DIGITS = 4 unless noted):
- Reset then slowena held high, up, for 10000 cycles -> q steps 0000 .. 9999, then 0000. ovf pulses exactly once, in the cycle after 9999 -> 0000. tc high only while q = 9999.
- load_val = 0x0199, load pulse, then one up step -> q = 0x0199, then 0x0200 (carry across two digits). load_err stays 0.
- Load 0x0000, then one down step with WRAP = 1 -> q = 0x9999 and ovf = 1. Repeat with WRAP = 0 -> q stays 0x0000 and ovf = 1.
- load_val = 0x12A4 -> q = 0x1204 and load_err = 1 for one cycle. Same test with load and slowena both high -> load wins and no step occurs.
- reset asserted together with load and slowena at q = 0x5555 -> q = 0x0000, ovf = 0, load_err = 0. Then slowena low for 20 cycles -> q holds at 0x0000.
- Two instances with DIGITS = 1 cascaded through tc -> slowena, up, 100 steps -> combined count goes 00 .. 99, then 00, matching a single DIGITS = 2 instance cycle-for-cycle.
